// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Parametrised register file with a per-register pending-write scoreboard.
//   Decode reads operands and marks destinations as pending at issue.
//   Writeback stores results and clears the pending mark.
//   pend_cnt tracks how many registers are currently pending.
//   Register 0 is hard-wired to zero and can never be marked pending.
//
// Optional feature (compile-time macro RF_BYPASS_EN):
//   When defined, a read of the register being written on this cycle returns
//   wdata combinationally, and that port's rbusy is forced low.
//   When undefined, reads return the stored value only.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (clears data and scoreboard)
//   we         in   writeback enable
//   waddr      in   writeback register
//   wdata      in   writeback data
//   raddr      in   NREAD packed read addresses, port 0 in LSBs
//   rdata      out  NREAD packed read data, combinational
//   rbusy      out  per-port pending flag of the addressed register, combinational
//   issue_en   in   decode issued an instruction writing issue_addr
//   issue_addr in   destination register of the issued instruction
//   flush      in   discard all pending marks
//   pend_cnt   out  number of pending registers, registered
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic                    flush,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [DEPTH-1:0]  set_mask_s;
  logic [DEPTH-1:0]  clr_mask_s;
  logic [ADDR_W:0]   pend_cnt_r;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              wr_s;
  logic              issue_set_s;
  logic              wr_clr_s;
  logic              inc_s;
  logic              dec_s;

  // Scoreboard next state: flush wins, then issue-set, then write-clear.
  always_comb begin
    wr_s        = we && (waddr != {ADDR_W{1'b0}});
    issue_set_s = issue_en && (issue_addr != {ADDR_W{1'b0}});
    // A write to the register being re-issued on the same edge must not clear
    // it: the newly issued instruction is now the outstanding producer.
    wr_clr_s    = wr_s && !(issue_set_s && (issue_addr == waddr));
    set_mask_s  = {{(DEPTH-1){1'b0}}, issue_set_s} << issue_addr;
    clr_mask_s  = {{(DEPTH-1){1'b0}}, wr_clr_s} << waddr;
    // Count only real transitions so pend_cnt stays equal to popcount(busy).
    inc_s       = issue_set_s && !busy_r[issue_addr];
    dec_s       = wr_clr_s && busy_r[waddr];
    if (flush) begin
      busy_nxt_s = {DEPTH{1'b0}};
      cnt_nxt_s  = {(ADDR_W+1){1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
      cnt_nxt_s  = pend_cnt_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
    end
  end

  // Scoreboard and pending counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= {DEPTH{1'b0}};
      pend_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      pend_cnt_r <= cnt_nxt_s;
    end
  end

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign pend_cnt = pend_cnt_r;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic              hit_s;

    assign ra_s = raddr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    // Forwarding is suppressed during reset so every port reads zero.
    assign hit_s = !rst && wr_s && (waddr == ra_s);
`else
    assign hit_s = 1'b0;
`endif
    assign rdata[k*DATA_W +: DATA_W] = (ra_s == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} :
                                       hit_s ? wdata : mem_r[ra_s];
    // Forwarded data is final, so the port no longer needs to stall.
    assign rbusy[k] = busy_r[ra_s] & ~hit_s;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard-style bench for rf_scoreboard (default parameters).
// The driver applies one set of inputs per cycle, computes the expected
// read data, busy flags and pending count from a plain array model and
// queues them; a monitor pops and compares on every falling edge.
module tb_rf_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              flush;
  logic [AW:0]       pend_cnt;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .flush     (flush),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and set of pending registers.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  typedef struct {
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [AW:0]      cnt;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   n_id  = 0;

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s chk#%0d: got %h, expected %h", name, id, act, req);
    end
  endtask

  // Monitor: compare DUT outputs with the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rdata",    mon_e.id, 64'(rdata),    64'(mon_e.rdata));
      check("rbusy",    mon_e.id, 64'(rbusy),    64'(mon_e.rbusy));
      check("pend_cnt", mon_e.id, 64'(pend_cnt), 64'(mon_e.cnt));
    end
  end

  task automatic push_expect();
    exp_t e;
    int   a;
    int   c;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end
    for (int k = 0; k < NR; k++) begin
      a = int'(raddr[k*AW +: AW]);
      if (rst || a == 0) begin
        e.rdata[k*DW +: DW] = '0;
        e.rbusy[k]          = 1'b0;
      end else begin
        e.rdata[k*DW +: DW] = m_mem[a];
        e.rbusy[k]          = m_busy[a];
`ifdef RF_BYPASS_EN
        if (we && int'(waddr) == a) begin
          e.rdata[k*DW +: DW] = wdata;
          e.rbusy[k]          = 1'b0;
        end
`endif
      end
    end
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    e.cnt = c[AW:0];
    e.id  = n_id;
    n_id++;
    exp_q.push_back(e);
  endtask

  // One cycle: apply inputs, queue expectation, clock, advance the model.
  task automatic drive(input logic w, input int wa, input logic [DW-1:0] wd,
                       input logic ie, input int ia, input logic fl,
                       input int r0, input int r1);
    we         = w;
    waddr      = wa[AW-1:0];
    wdata      = wd;
    issue_en   = ie;
    issue_addr = ia[AW-1:0];
    flush      = fl;
    raddr      = {r1[AW-1:0], r0[AW-1:0]};
    push_expect();
    @(posedge clk);
    if (!rst) begin
      if (w && wa != 0) m_mem[wa] = wd;
      if (fl) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else begin
        if (w && wa != 0) m_busy[wa] = 1'b0;
        if (ie && ia != 0) m_busy[ia] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int wa, ia, r0, r1;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk); #1;

    // Reads during reset, including an attempted write/issue.
    drive(1'b1, 5, 32'h0000_1111, 1'b1, 5, 1'b0, 5, 5);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, a, DEPTH-1-a);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, a, DEPTH-1-a);

    // Basic write/read and r0 behaviour.
    drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 5, 0);
    drive(1'b1, 0, 32'h0000_1234, 1'b1, 0, 1'b0, 0, 5);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0, 5);

    // Same-cycle write and read (bypass-dependent).
    drive(1'b1, 7, 32'hA5A5_A5A5, 1'b0, 0, 1'b0, 7, 5);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 7, 7);

    // Issue / re-issue / write-clear / write to non-busy.
    drive(1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 3, 4);
    drive(1'b0, 0, 32'h0, 1'b1, 4, 1'b0, 3, 4);
    drive(1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 3, 4);
    drive(1'b1, 3, 32'h0000_0011, 1'b0, 0, 1'b0, 3, 4);
    drive(1'b1, 9, 32'h0000_0022, 1'b0, 0, 1'b0, 3, 9);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 3, 9);

    // Issue and write on the same edge.
    drive(1'b0, 0, 32'h0, 1'b1, 8, 1'b0, 8, 4);
    drive(1'b1, 8, 32'h0000_0033, 1'b1, 8, 1'b0, 8, 4);
    drive(1'b1, 4, 32'h0000_0044, 1'b1, 10, 1'b0, 8, 4);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 10, 4);

    // Flush beats issue; the write still lands.
    drive(1'b0, 0, 32'h0, 1'b1, 2, 1'b0, 2, 6);
    drive(1'b0, 0, 32'h0, 1'b1, 6, 1'b0, 2, 6);
    drive(1'b0, 0, 32'h0, 1'b1, 11, 1'b0, 6, 11);
    drive(1'b1, 6, 32'h0000_0055, 1'b1, 12, 1'b1, 6, 12);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 6, 12);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 2, 11);

    // Reset mid-operation with data and pending marks present.
    drive(1'b1, 13, 32'h0000_0077, 1'b1, 14, 1'b0, 13, 6);
    drive(1'b0, 0, 32'h0, 1'b1, 15, 1'b0, 14, 13);
    rst = 1'b1;
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 14, 6);
    rst = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 13, 15);

    // Randomised traffic on a small address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      wa = int'($urandom_range(0, 15));
      ia = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15));
      r0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15));
      r1 = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, 15));
      rst = ($urandom_range(0, 149) == 0);
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ia,
            ($urandom_range(0, 24) == 0), r0, r1);
    end
    rst = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 1, 2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the pipelined MIPS core, a successor to the single-write, two-read 32×32 file. Adds configurable width, depth and read-port count. Adds an asynchronous clear of all registers, and a per-register pending-write scoreboard with a pending counter, so decode can detect RAW hazards. Sits between decode (reads, issue) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of independent read ports (packed, port 0 in LSBs)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we  in  1  writeback enable
- waddr  in  ADDR_W  writeback register
- wdata  in  DATA_W  writeback data
- raddr  in  NREAD*ADDR_W  read addresses
- rdata  out  NREAD*DATA_W  read data, combinational
- rbusy  out  NREAD  pending-write flag per read port, combinational
- issue_en  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination of the issued instruction
- flush  in  1  pipeline flush; discards all pending marks
- pend_cnt  out  ADDR_W+1  number of registers currently marked pending, registered

## Operation
- Register 0 reads 0 always. Writes to it are dropped. Issue to it is ignored, so busy[0] stays 0.
- Write: on a clock edge with we=1 and waddr≠0, mem[waddr]←wdata.
- Read port k: rdata[k] = 0 if raddr[k]=0. Otherwise mem[raddr[k]], or wdata when bypassing (see Configuration).
- Scoreboard busy[1..2**ADDR_W-1] is updated on each edge with this priority:
  - flush=1: all busy bits ←0. Issue is ignored. The write still updates mem.
  - else if issue_en and issue_addr≠0: busy[issue_addr]←1. This also applies when the same edge writes that register, because the new producer wins.
  - a write with we=1 to waddr≠0 clears busy[waddr], unless the rule above sets the same bit.
- The issue and write addresses are independent. When they differ, both take effect on the same edge.
- pend_cnt always equals popcount(busy) after each edge. Track it incrementally:
  - +1 when a clear bit is set.
  - −1 when a set bit is cleared.
  - net 0 when one edge sets one bit and clears another.
  - ←0 on flush.
- Re-issue to an already-busy register leaves pend_cnt unchanged.
- A write to a non-busy register leaves busy and pend_cnt unchanged.
- Read addresses out of range cannot occur, because depth is 2**ADDR_W.

## Timing
- Reset, effective immediately and not waiting for clk:
  - all mem entries ←0, all busy ←0, pend_cnt ←0.
  - Consequently every rdata reads 0 and every rbusy is 0 while rst is high.
- Reset asserted mid-operation discards all pending marks and data. The first edge after rst deasserts behaves as a normal cycle.
- Read latency: 0 cycles, combinational from raddr and state.
- Write latency: visible on rdata from the cycle after the write edge. With bypass it is also visible in the same cycle.
- Issue latency: rbusy rises the cycle after the issue edge.
- pend_cnt changes only on clock edges or reset.

## Configuration
- Macro RF_BYPASS_EN.
- Defined:
  - When we=1, waddr≠0 and raddr[k]=waddr, port k returns wdata in the same cycle.
  - rbusy[k] is forced to 0 for that port, since the data is forwarded.
- Undefined:
  - rdata[k] returns the stored value; new data appears on the next cycle.
  - rbusy[k] = busy[raddr[k]] unmodified.
- The scoreboard and pend_cnt edge behaviour is identical in both builds.

## Test plan
- Reset, then read all addresses on both ports -> every rdata=0, rbusy=0, pend_cnt=0. Pulse rst while registers hold data -> all clear without a clock edge.
- Write 0xDEADBEEF to r5, then read r5 and r0 on the next cycle -> r5=0xDEADBEEF, r0=0. A write of 0x1234 to r0 leaves r0=0.
- Same-cycle write of 0xA5A5A5A5 to r7 with raddr[0]=7 (r7 previously 0):
  - RF_BYPASS_EN defined -> rdata[0]=0xA5A5A5A5.
  - RF_BYPASS_EN undefined -> rdata[0]=0, and 0xA5A5A5A5 on the next cycle.
- Issue r3, then r4, then r3 again -> pend_cnt 1, 2, 2 and rbusy for r3=1. Write r3 -> pend_cnt=1, r3 not busy. Write r9 (never issued) -> pend_cnt stays 1.
- Same edge: issue r8 and write r8 (r8 busy beforehand) -> r8 stays busy, pend_cnt unchanged. Same edge: issue r10 and write busy r4 -> pend_cnt unchanged, r10 busy, r4 clear.
- With r2, r6 and r11 busy, assert flush together with issue r12 and a write of 0x55 to r6:
  - busy all clear and pend_cnt=0 next cycle.
  - r6 reads 0x55.
